// File: rtl/tank_pkg.sv
// Shared definitions for the enemy-tank behaviour controller:
// heading encodings, FSM state type, drive/cooldown frame constants.
package tank_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DECIDE   = 3'd1,
      ST_DRIVE    = 3'd2,
      ST_FIRE     = 3'd3,
      ST_COOLDOWN = 3'd4
   } tank_state_t;

   localparam int DRIVE_UNIT_FRAMES       = 8;
   localparam int COOLDOWN_FRAMES_DEFAULT = 30;

   // Drive length in frames for a 3-bit selector: 8, 16, ... 64.
   function automatic logic [6:0] drive_frames(input logic [2:0] sel);
      return 7'(({4'd0, sel} + 7'd1) * DRIVE_UNIT_FRAMES);
   endfunction

endpackage

// File: rtl/frame_countdown.sv
// 7-bit loadable frame down-counter shared by the DRIVE and COOLDOWN phases.
// clear wins over load, load wins over dec; it never wraps below zero.
module frame_countdown (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [6:0] load_value,
   input  logic       dec,
   input  logic       clear,
   output logic [6:0] value,
   output logic       zero
);

   // Counter register: clear, load or count down one frame.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         value <= 7'd0;
      end else if (load) begin
         value <= load_value;
      end else if (dec && (value != 7'd0)) begin
         value <= value - 7'd1;
      end
   end

   assign zero = (value == 7'd0);

endmodule

// File: rtl/tank_ai.sv
// Enemy-tank behaviour controller. Samples the LFSR word once per frame in
// DECIDE to pick a heading/duration or a shot, then paces step pulses and
// the cooldown with frame_tick.
// Optional feature macro: TANK_AI_AIM_EN adds player_dir and lets a drive
// decision with rnd[7:6] == 2'b00 head toward the player.
//
// Handshake: fire_req is a level request raised on entering FIRE and held
// until fire_ack is seen in the same cycle as fire_req; the request drops
// the cycle after the ack. fire_ack outside FIRE has no effect.
module tank_ai
   import tank_pkg::*;
#(
   parameter int NUM_BITS        = 8,
   parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                frame_tick,
   input  logic                enable,
   input  logic [NUM_BITS-1:0] rnd,
   input  logic                blocked,
   input  logic                fire_ack,
`ifdef TANK_AI_AIM_EN
   input  logic [1:0]          player_dir,
`endif
   output logic [1:0]          dir,
   output logic                move,
   output logic                fire_req,
   output logic                rnd_used,
   output tank_state_t         dbg_state
);

   tank_state_t state, state_next;
   logic [1:0]  dir_next;
   logic        move_next;
   logic        fire_next;
   logic        used_next;
   logic        cnt_load;
   logic [6:0]  cnt_load_value;
   logic        cnt_dec;
   logic        cnt_clear;
   logic [6:0]  cnt;
   logic        cnt_zero;
   logic        cnt_last;
   logic [1:0]  heading;

`ifdef TANK_AI_AIM_EN
   assign heading = (rnd[7:6] == 2'b00) ? player_dir : rnd[1:0];
`else
   assign heading = rnd[1:0];
`endif

   // A tick on which the counter is at 1 (or already 0) finishes the phase.
   assign cnt_last = cnt_zero || (cnt == 7'd1);

   frame_countdown u_countdown (
      .clk        (clk),
      .reset      (reset),
      .load       (cnt_load),
      .load_value (cnt_load_value),
      .dec        (cnt_dec),
      .clear      (cnt_clear),
      .value      (cnt),
      .zero       (cnt_zero)
   );

   // Next-state, next-output and counter control.
   always_comb begin
      state_next     = state;
      dir_next       = dir;
      move_next      = 1'b0;
      fire_next      = 1'b0;
      used_next      = 1'b0;
      cnt_load       = 1'b0;
      cnt_load_value = 7'd0;
      cnt_dec        = 1'b0;
      cnt_clear      = 1'b0;
      if (!enable) begin
         state_next = ST_IDLE;
         cnt_clear  = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               state_next = ST_DECIDE;
            end
            ST_DECIDE: begin
               if (frame_tick) begin
                  used_next = 1'b1;
                  if (rnd[7:5] == 3'b111) begin
                     state_next = ST_FIRE;
                     fire_next  = 1'b1;
                  end else begin
                     dir_next       = heading;
                     cnt_load       = 1'b1;
                     cnt_load_value = drive_frames(rnd[4:2]);
                     state_next     = ST_DRIVE;
                  end
               end
            end
            ST_DRIVE: begin
               if (frame_tick) begin
                  if (blocked) begin
                     cnt_clear  = 1'b1;
                     state_next = ST_DECIDE;
                  end else begin
                     move_next = 1'b1;
                     cnt_dec   = 1'b1;
                     if (cnt_last) begin
                        state_next = ST_DECIDE;
                     end
                  end
               end
            end
            ST_FIRE: begin
               if (fire_ack) begin
                  cnt_load       = 1'b1;
                  cnt_load_value = 7'(COOLDOWN_FRAMES);
                  state_next     = ST_COOLDOWN;
               end else begin
                  fire_next = 1'b1;
               end
            end
            ST_COOLDOWN: begin
               if (frame_tick) begin
                  cnt_dec = 1'b1;
                  if (cnt_last) begin
                     state_next = ST_DECIDE;
                  end
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         dir      <= DIR_UP;
         move     <= 1'b0;
         fire_req <= 1'b0;
         rnd_used <= 1'b0;
      end else begin
         state    <= state_next;
         dir      <= dir_next;
         move     <= move_next;
         fire_req <= fire_next;
         rnd_used <= used_next;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_tank_ai.sv
// Self-checking bench for tank_ai: directed decisions, drive runs, blocking,
// shots with cooldown, ack/tick collision, enable aborts, aim and a short
// randomized drive phase. Expected headings are queued at each decision and
// checked when rnd_used pulses.
module tb_tank_ai;
   import tank_pkg::*;

   logic        clk;
   logic        reset;
   logic        frame_tick;
   logic        enable;
   logic [7:0]  rnd;
   logic        blocked;
   logic        fire_ack;
`ifdef TANK_AI_AIM_EN
   logic [1:0]  player_dir;
`endif
   logic [1:0]  dir;
   logic        move;
   logic        fire_req;
   logic        rnd_used;
   tank_state_t dbg_state;

   int          n_compared;
   int          n_mismatched;
   int          move_count;
   logic        last_move;
   logic        last_used;
   logic [1:0]  exp_q[$];

   tank_ai #(.NUM_BITS(8), .COOLDOWN_FRAMES(30)) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .enable     (enable),
      .rnd        (rnd),
      .blocked    (blocked),
      .fire_ack   (fire_ack),
`ifdef TANK_AI_AIM_EN
      .player_dir (player_dir),
`endif
      .dir        (dir),
      .move       (move),
      .fire_req   (fire_req),
      .rnd_used   (rnd_used),
      .dbg_state  (dbg_state)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Monitor: count step pulses, check heading against the scoreboard.
   always @(negedge clk) begin
      if (move === 1'b1) move_count++;
      if (rnd_used === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rnd_used", 32'd1, 32'd0);
         end else begin
            check("dir_at_decision", 32'(dir), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One frame_tick pulse; captures the registered response, then spaces frames.
   task automatic frame();
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      last_move  = move;
      last_used  = rnd_used;
      cycles(3);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   // Decision in DECIDE: queue the expected heading, present rnd, tick.
   task automatic decide(input logic [7:0] r, input logic [1:0] exp_dir);
      exp_q.push_back(exp_dir);
      rnd = r;
      frame();
      check("rnd_used_pulse", 32'(last_used), 32'd1);
      rnd = 8'($urandom_range(0, 255));
   endtask

   task automatic check_state(input string tag, input tank_state_t exp);
      check(tag, 32'(dbg_state), 32'(exp));
   endtask

   initial begin
      int base;
      logic [7:0] r;
      logic [1:0] exp_dir;
      int n;
      n_compared   = 0;
      n_mismatched = 0;
      move_count   = 0;
      frame_tick   = 1'b0;
      enable       = 1'b0;
      rnd          = 8'h00;
      blocked      = 1'b0;
      fire_ack     = 1'b0;
      last_move    = 1'b0;
      last_used    = 1'b0;
`ifdef TANK_AI_AIM_EN
      player_dir   = 2'd0;
`endif
      reset        = 1'b1;
      @(posedge clk);
      #1;
      cycles(2);
      check_state("reset_state", ST_IDLE);
      check("reset_dir", 32'(dir), 32'd0);
      check("reset_move", 32'(move), 32'd0);
      check("reset_fire_req", 32'(fire_req), 32'd0);
      check("reset_rnd_used", 32'(rnd_used), 32'd0);
      reset = 1'b0;

      // Idle with enable low.
      for (int i = 0; i < 5; i++) begin
         frame();
         check("idle_dir", 32'(dir), 32'd0);
         check("idle_move", 32'(last_move), 32'd0);
         check("idle_fire_req", 32'(fire_req), 32'd0);
      end
      check_state("idle_stays", ST_IDLE);

      // Drive: rnd 8'h05 -> heading right, 16 frames.
      enable = 1'b1;
      cycles(1);
      check_state("idle_to_decide", ST_DECIDE);
      decide(8'h05, DIR_RIGHT);
      check_state("decide_to_drive", ST_DRIVE);
      check("no_move_on_decision", 32'(last_move), 32'd0);
      base = move_count;
      frames(15);
      check_state("drive_15", ST_DRIVE);
      frame();
      check("drive_16_pulses", 32'(move_count - base), 32'd16);
      check_state("drive_done", ST_DECIDE);

      // Blocked on the third drive frame: 2 pulses, then resample.
      decide(8'h05, DIR_RIGHT);
      base = move_count;
      frames(2);
      blocked = 1'b1;
      frame();
      blocked = 1'b0;
      check("blocked_no_pulse", 32'(last_move), 32'd0);
      check("blocked_2_pulses", 32'(move_count - base), 32'd2);
      check_state("blocked_to_decide", ST_DECIDE);

      // Fire: heading unchanged, request held, ack drops it, 30-frame cooldown.
      decide(8'hE2, DIR_RIGHT);
      check_state("fire_state", ST_FIRE);
      for (int i = 0; i < 5; i++) begin
         check("fire_req_held", 32'(fire_req), 32'd1);
         cycles(1);
      end
      frame();
      check_state("fire_ignores_tick", ST_FIRE);
      check("fire_req_after_tick", 32'(fire_req), 32'd1);
      fire_ack = 1'b1;
      cycles(1);
      fire_ack = 1'b0;
      check("fire_req_after_ack", 32'(fire_req), 32'd0);
      check_state("ack_to_cooldown", ST_COOLDOWN);
      base = move_count;
      frames(29);
      check_state("cooldown_29", ST_COOLDOWN);
      frame();
      check_state("cooldown_done", ST_DECIDE);
      check("cooldown_no_move", 32'(move_count - base), 32'd0);

      // Ack coincident with a tick: full cooldown still applies.
      decide(8'hE2, DIR_RIGHT);
      fire_ack   = 1'b1;
      frame_tick = 1'b1;
      cycles(1);
      fire_ack   = 1'b0;
      frame_tick = 1'b0;
      check("collide_fire_req", 32'(fire_req), 32'd0);
      check_state("collide_cooldown", ST_COOLDOWN);
      cycles(2);
      frames(29);
      check_state("collide_29", ST_COOLDOWN);
      frame();
      check_state("collide_done", ST_DECIDE);

      // Enable dropped mid-DRIVE, coincident with a tick.
      decide(8'h1E, DIR_DOWN);
      base = move_count;
      frames(3);
      enable     = 1'b0;
      frame_tick = 1'b1;
      cycles(1);
      frame_tick = 1'b0;
      check_state("abort_drive_idle", ST_IDLE);
      check("abort_drive_move", 32'(move), 32'd0);
      check("abort_drive_dir", 32'(dir), 32'(DIR_DOWN));
      cycles(3);
      check("abort_drive_pulses", 32'(move_count - base), 32'd3);
      enable = 1'b1;
      cycles(1);
      check_state("reenable_decide", ST_DECIDE);

      // Enable dropped mid-FIRE.
      decide(8'hE2, DIR_DOWN);
      check("abort_fire_req_before", 32'(fire_req), 32'd1);
      enable = 1'b0;
      cycles(1);
      check_state("abort_fire_idle", ST_IDLE);
      check("abort_fire_req", 32'(fire_req), 32'd0);
      check("abort_fire_dir", 32'(dir), 32'(DIR_DOWN));
      enable = 1'b1;
      cycles(1);

      // Stray ack with no request pending is ignored.
      fire_ack = 1'b1;
      cycles(1);
      fire_ack = 1'b0;
      check_state("stray_ack", ST_DECIDE);
      check("stray_ack_fire_req", 32'(fire_req), 32'd0);

      // Aim: rnd 8'h01 with player heading left.
`ifdef TANK_AI_AIM_EN
      player_dir = 2'd3;
      decide(8'h01, DIR_LEFT);
`else
      decide(8'h01, DIR_RIGHT);
`endif
      base = move_count;
      frames(8);
      check("aim_8_pulses", 32'(move_count - base), 32'd8);
      check_state("aim_done", ST_DECIDE);

      // Randomized drive decisions (shot pattern excluded).
      for (int k = 0; k < 6; k++) begin
         r = 8'($urandom_range(0, 255)) & 8'hDF;
         exp_dir = r[1:0];
`ifdef TANK_AI_AIM_EN
         if (r[7:6] == 2'b00) exp_dir = player_dir;
`endif
         n = (int'(r[4:2]) + 1) * 8;
         decide(r, exp_dir);
         base = move_count;
         frames(n);
         check("rand_pulses", 32'(move_count - base), 32'(n));
         check_state("rand_done", ST_DECIDE);
      end

      cycles(2);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      // Mid-operation reset clears heading and returns to IDLE.
      decide(8'h1F, DIR_LEFT);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      check_state("midreset_state", ST_IDLE);
      check("midreset_dir", 32'(dir), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
